// File: rtl/pipe_pkg.sv
// Shared definitions for elastic pipeline stages: occupancy encoding,
// default bubble instruction and payload word slicing helper.
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } occ_e;

    localparam logic [31:0] NOP_DEFAULT = 32'd0;

    // LSB position of payload word k in a packed bus of w-bit words
    function automatic int word_lsb(input int k, input int w);
        return k * w;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter for pipeline performance events; clamps at all-ones.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {CNT_W{1'b1}})) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!clrn) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline stage register: instruction plus payload words with
// valid/ready handshake, optional 2-entry skid buffer, flush and stall counter.
module pipe_stage_elastic
    import pipe_pkg::*;
#(
    parameter int              IR_W     = 32,
    parameter int              DATA_W   = 32,
    parameter int              NUM_DATA = 2,
    parameter int              SKID     = 1,
    parameter logic [IR_W-1:0] NOP      = IR_W'(NOP_DEFAULT),
    parameter int              CNT_W    = 16
) (
    input  logic                       clk,
    input  logic                       clrn,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [IR_W-1:0]            in_ir,
    input  logic [NUM_DATA*DATA_W-1:0] in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [IR_W-1:0]            out_ir,
    output logic [NUM_DATA*DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]           stall_cnt
);

    localparam int PW = NUM_DATA * DATA_W;

    occ_e            state_q, state_d;
    logic [IR_W-1:0] main_ir_q, main_ir_d;
    logic [PW-1:0]   main_data_q, main_data_d;
    logic [IR_W-1:0] skid_ir_q, skid_ir_d;
    logic [PW-1:0]   skid_data_q, skid_data_d;

    logic ready_base;
    logic in_xfer;
    logic out_xfer;

    // Skid variant registers ready; pass-through variant looks at out_ready
    generate
        if (SKID != 0) begin : g_skid
            assign ready_base = (state_q != ST_TWO);
        end else begin : g_noskid
            assign ready_base = ~out_valid | out_ready;
        end
    endgenerate

    assign in_ready  = ready_base & ~flush & clrn;
    assign out_valid = (state_q != ST_EMPTY);
    assign in_xfer   = in_valid & in_ready;
    assign out_xfer  = out_valid & out_ready;

    always_comb begin
        state_d     = state_q;
        main_ir_d   = main_ir_q;
        main_data_d = main_data_q;
        skid_ir_d   = skid_ir_q;
        skid_data_d = skid_data_q;
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_xfer) begin
                        state_d     = ST_ONE;
                        main_ir_d   = in_ir;
                        main_data_d = in_data;
                    end
                end
                ST_ONE: begin
                    if (in_xfer && out_xfer) begin
                        main_ir_d   = in_ir;
                        main_data_d = in_data;
                    end else if (in_xfer && (SKID != 0)) begin
                        state_d     = ST_TWO;
                        skid_ir_d   = in_ir;
                        skid_data_d = in_data;
                    end else if (out_xfer) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (out_xfer) begin
                        state_d     = ST_ONE;
                        main_ir_d   = skid_ir_q;
                        main_data_d = skid_data_q;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!clrn) begin
            state_q     <= ST_EMPTY;
            main_ir_q   <= NOP;
            main_data_q <= '0;
            skid_ir_q   <= NOP;
            skid_data_q <= '0;
        end else begin
            state_q     <= state_d;
            main_ir_q   <= main_ir_d;
            main_data_q <= main_data_d;
            skid_ir_q   <= skid_ir_d;
            skid_data_q <= skid_data_d;
        end
    end

    // Payload keeps its last value when empty; only the instruction bubbles
    assign out_ir   = out_valid ? main_ir_q : NOP;
    assign out_data = main_data_q;

    sat_counter #(
        .CNT_W(CNT_W)
    ) u_stall_cnt (
        .clk  (clk),
        .clrn (clrn),
        .inc  (out_valid & ~out_ready),
        .count(stall_cnt)
    );

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Directed bench for pipe_stage_elastic: skid, pass-through and 4-bit counter instances.
module tb_pipe_stage_elastic;
    import pipe_pkg::*;

    localparam int IR_W   = 32;
    localparam int DATA_W = 32;
    localparam int ND     = 2;
    localparam int PW     = ND * DATA_W;

    logic clk;
    logic clrn;

    logic a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [IR_W-1:0] a_in_ir, a_out_ir;
    logic [PW-1:0]   a_in_data, a_out_data;
    logic [15:0]     a_stall;

    logic b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [IR_W-1:0] b_in_ir, b_out_ir;
    logic [PW-1:0]   b_in_data, b_out_data;
    logic [15:0]     b_stall;

    logic c_flush, c_in_valid, c_in_ready, c_out_valid, c_out_ready;
    logic [IR_W-1:0] c_in_ir, c_out_ir;
    logic [PW-1:0]   c_in_data, c_out_data;
    logic [3:0]      c_stall;

    int checks = 0;
    int errors = 0;

    pipe_stage_elastic #(.IR_W(IR_W), .DATA_W(DATA_W), .NUM_DATA(ND), .SKID(1), .CNT_W(16)) u_dut_a (
        .clk(clk), .clrn(clrn), .flush(a_flush), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_ir(a_in_ir), .in_data(a_in_data), .out_valid(a_out_valid), .out_ready(a_out_ready),
        .out_ir(a_out_ir), .out_data(a_out_data), .stall_cnt(a_stall));

    pipe_stage_elastic #(.IR_W(IR_W), .DATA_W(DATA_W), .NUM_DATA(ND), .SKID(0), .CNT_W(16)) u_dut_b (
        .clk(clk), .clrn(clrn), .flush(b_flush), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_ir(b_in_ir), .in_data(b_in_data), .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_ir(b_out_ir), .out_data(b_out_data), .stall_cnt(b_stall));

    pipe_stage_elastic #(.IR_W(IR_W), .DATA_W(DATA_W), .NUM_DATA(ND), .SKID(1), .CNT_W(4)) u_dut_c (
        .clk(clk), .clrn(clrn), .flush(c_flush), .in_valid(c_in_valid), .in_ready(c_in_ready),
        .in_ir(c_in_ir), .in_data(c_in_data), .out_valid(c_out_valid), .out_ready(c_out_ready),
        .out_ir(c_out_ir), .out_data(c_out_data), .stall_cnt(c_stall));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Payload word k of an entry = ir*16 + k, so each entry's data is distinct
    function automatic logic [PW-1:0] mkdata(input logic [IR_W-1:0] ir);
        logic [PW-1:0] d;
        d = '0;
        for (int k = 0; k < ND; k++) begin
            d[word_lsb(k, DATA_W) +: DATA_W] = DATA_W'(ir * 16 + k);
        end
        return d;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        clrn = 1'b0;
        a_flush = 0; a_in_valid = 1; a_out_ready = 1; a_in_ir = 32'h99; a_in_data = mkdata(32'h99);
        b_flush = 0; b_in_valid = 1; b_out_ready = 1; b_in_ir = 32'h98; b_in_data = mkdata(32'h98);
        c_flush = 0; c_in_valid = 0; c_out_ready = 1; c_in_ir = 0;      c_in_data = '0;
        #1;
        chk("rst_in_ready_comb", a_in_ready, 0);

        // Reset held two cycles with input offered
        tick();
        tick();
        chk("rst_in_ready", a_in_ready, 0);
        chk("rst_out_valid", a_out_valid, 0);
        chk("rst_out_ir", a_out_ir, 0);
        chk("rst_out_data", a_out_data, 0);
        chk("rst_stall", a_stall, 0);
        chk("rst_b_in_ready", b_in_ready, 0);
        clrn = 1; a_in_valid = 0; b_in_valid = 0;
        tick();
        chk("rst_release_empty", a_out_valid, 0);
        chk("rst_release_b_empty", b_out_valid, 0);
        $display("reset: out_valid=%0d stall=%0d", a_out_valid, a_stall);

        // Streaming with out_ready=1
        a_out_ready = 1; a_in_valid = 1;
        a_in_ir = 32'h11; a_in_data = mkdata(32'h11);
        #1;
        chk("str_in_ready0", a_in_ready, 1);
        tick();
        chk("str_ir_11", a_out_ir, 32'h11);
        chk("str_valid_11", a_out_valid, 1);
        chk("str_data_11", a_out_data, mkdata(32'h11));
        $display("stream: out_ir=%0h", a_out_ir);
        a_in_ir = 32'h22; a_in_data = mkdata(32'h22);
        #1;
        chk("str_in_ready1", a_in_ready, 1);
        tick();
        chk("str_ir_22", a_out_ir, 32'h22);
        $display("stream: out_ir=%0h", a_out_ir);
        a_in_ir = 32'h33; a_in_data = mkdata(32'h33);
        #1;
        chk("str_in_ready2", a_in_ready, 1);
        tick();
        chk("str_ir_33", a_out_ir, 32'h33);
        chk("str_data_33", a_out_data, mkdata(32'h33));
        $display("stream: out_ir=%0h", a_out_ir);
        a_in_valid = 0;
        tick();
        chk("str_drain_valid", a_out_valid, 0);
        chk("str_drain_nop", a_out_ir, 0);
        chk("str_data_hold", a_out_data, mkdata(32'h33));
        chk("str_stall", a_stall, 0);

        // Backpressure fills the skid
        a_out_ready = 0; a_in_valid = 1;
        a_in_ir = 32'hA1; a_in_data = mkdata(32'hA1);
        tick();
        chk("bp_ir_a1", a_out_ir, 32'hA1);
        chk("bp_in_ready_one", a_in_ready, 1);
        chk("bp_stall0", a_stall, 0);
        a_in_ir = 32'hA2; a_in_data = mkdata(32'hA2);
        tick();
        chk("bp_in_ready_two", a_in_ready, 0);
        chk("bp_stall1", a_stall, 1);
        chk("bp_head_a1", a_out_ir, 32'hA1);
        a_in_valid = 0;
        tick();
        chk("bp_stall2", a_stall, 2);
        tick();
        chk("bp_stall3", a_stall, 3);
        chk("bp_head_a1_hold", a_out_ir, 32'hA1);
        $display("backpressure: head=%0h stall=%0d", a_out_ir, a_stall);
        a_out_ready = 1;
        tick();
        chk("bp_ir_a2", a_out_ir, 32'hA2);
        chk("bp_data_a2", a_out_data, mkdata(32'hA2));
        chk("bp_valid_a2", a_out_valid, 1);
        chk("bp_stall_hold", a_stall, 3);
        tick();
        chk("bp_drained", a_out_valid, 0);
        $display("backpressure: drained stall=%0d", a_stall);

        // Flush while holding two entries
        a_out_ready = 0; a_in_valid = 1;
        a_in_ir = 32'hB1; a_in_data = mkdata(32'hB1);
        tick();
        a_in_ir = 32'hB2; a_in_data = mkdata(32'hB2);
        tick();
        chk("fl_two_ready", a_in_ready, 0);
        chk("fl_stall_pre", a_stall, 4);
        a_flush = 1; a_out_ready = 1;
        a_in_ir = 32'hB3; a_in_data = mkdata(32'hB3);
        #1;
        chk("fl_in_ready", a_in_ready, 0);
        tick();
        chk("fl_valid", a_out_valid, 0);
        chk("fl_nop", a_out_ir, 0);
        chk("fl_stall", a_stall, 4);
        a_flush = 0; a_in_valid = 0;
        tick();
        chk("fl_no_b3", a_out_valid, 0);
        tick();
        chk("fl_no_b3_2", a_out_valid, 0);
        $display("flush: out_valid=%0d stall=%0d", a_out_valid, a_stall);

        // Pass-through variant: combinational ready from out_ready
        b_out_ready = 0; b_in_valid = 1;
        b_in_ir = 32'hC1; b_in_data = mkdata(32'hC1);
        #1;
        chk("nsk_ready_empty", b_in_ready, 1);
        tick();
        chk("nsk_ir_c1", b_out_ir, 32'hC1);
        b_in_ir = 32'hC2; b_in_data = mkdata(32'hC2);
        #1;
        chk("nsk_ready_blocked", b_in_ready, 0);
        b_out_ready = 1;
        #1;
        chk("nsk_ready_comb", b_in_ready, 1);
        tick();
        chk("nsk_ir_c2", b_out_ir, 32'hC2);
        chk("nsk_valid_one", b_out_valid, 1);
        chk("nsk_data_c2", b_out_data, mkdata(32'hC2));
        b_in_valid = 0;
        tick();
        chk("nsk_drained", b_out_valid, 0);
        chk("nsk_stall", b_stall, 0);
        $display("noskid: out_valid=%0d stall=%0d", b_out_valid, b_stall);

        // 4-bit counter saturation
        c_out_ready = 0; c_in_valid = 1;
        c_in_ir = 32'hD1; c_in_data = mkdata(32'hD1);
        tick();
        c_in_valid = 0;
        for (int i = 0; i < 14; i++) tick();
        chk("sat_14", c_stall, 14);
        tick();
        chk("sat_15", c_stall, 15);
        for (int i = 0; i < 5; i++) tick();
        chk("sat_hold", c_stall, 15);
        chk("sat_head", c_out_ir, 32'hD1);
        $display("saturate: stall=%0d", c_stall);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_stage_elastic.md
Name: pipe_stage_elastic

Overview:
Parametrised elastic pipeline stage register for the processor datapath. It carries one instruction word plus NUM_DATA payload words between adjacent stages, such as memory to writeback. It adds valid/ready backpressure, an optional 2-entry skid buffer, and synchronous flush with NOP-bubble insertion. It also provides a saturating stall counter for performance visibility.

Parameters:
IR_W, 32, instruction word width
DATA_W, 32, width of each payload word
NUM_DATA, 2, number of payload words carried (e.g. ALU result, store data)
SKID, 1, 1 = 2-entry skid buffer with registered in_ready; 0 = single entry with pass-through ready
NOP, 0 (IR_W bits), instruction value presented when the stage is empty
CNT_W, 16, stall counter width

Ports:
clk  in  1  clock; all state changes on rising edge
clrn  in  1  reset, synchronous, active-low
flush  in  1  discard all held entries this cycle
in_valid  in  1  upstream entry offered
in_ready  out  1  stage can accept this cycle
in_ir  in  IR_W  upstream instruction
in_data  in  NUM_DATA*DATA_W  upstream payload; word k at bits [k*DATA_W +: DATA_W]
out_valid  out  1  downstream entry offered
out_ready  in  1  downstream accepts
out_ir  out  IR_W  head instruction; NOP when out_valid=0
out_data  out  NUM_DATA*DATA_W  head payload
stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0, saturating

Behaviour:
- Reset, when clrn=0 at an edge:
  - occupancy EMPTY, out_valid=0, out_ir=NOP, out_data=0, stall_cnt=0.
  - in_ready is forced 0 combinationally while clrn=0, so no input is accepted.
- Transfers: input transfer = in_valid & in_ready; output transfer = out_valid & out_ready.
- Latency is 1 cycle: an entry accepted at edge N appears on the outputs after edge N.
- Ordering is strict FIFO; entries are never duplicated or reordered.
- Occupancy states (SKID=1): EMPTY, ONE (main register holds the head), TWO (main plus skid register).
  - EMPTY + input -> ONE.
  - ONE + input, no output -> TWO; the input goes to skid.
  - ONE + input + output -> ONE; main is replaced by the input.
  - ONE + output only -> EMPTY.
  - TWO + output -> ONE; skid moves to main.
  - Every other combination holds state.
- in_ready (SKID=1) = (state != TWO) & ~flush & clrn. It depends on registered state only, never on out_ready.
- SKID=0:
  - Only EMPTY and ONE exist.
  - in_ready = (~out_valid | out_ready) & ~flush & clrn; this is a combinational path from out_ready.
  - ONE + input + output -> ONE.
- out_valid = (state != EMPTY).
- out_ir = main instruction when valid, else NOP.
- out_data holds its last value when empty. It is not zeroed except by reset.
- Flush:
  - At the edge, state goes to EMPTY and out_ir becomes NOP.
  - Any input offered that cycle is not accepted, because in_ready=0.
  - An output handshake in the flush cycle still counts as a completed transfer for downstream.
  - stall_cnt is not cleared by flush.
- Priority: reset > flush > transfers.
- stall_cnt increments at each edge where out_valid & ~out_ready, clamps at all-ones, and does not wrap.
- The stage is stateless with respect to instruction content: no decode, and no X-detection logic.

Decomposition:
- Shared package pipe_pkg holds:
  - the occupancy state encoding (EMPTY=2'd0, ONE=2'd1, TWO=2'd2);
  - the default NOP constant;
  - a helper function for payload word slicing.
- One sub-module is natural: sat_counter (parameter CNT_W; ports clk, clrn, inc, count). It is reusable for other pipeline performance counters.
- The storage registers stay inline.

Test Plan:
- Reset: hold clrn=0 for 2 cycles with in_valid=1 -> in_ready=0, out_valid=0, out_ir=0, stall_cnt=0; no entry appears after release.
- Streaming (SKID=1), out_ready=1: send in_ir 0x11,0x22,0x33 back-to-back -> out_ir 0x11,0x22,0x33 on consecutive cycles, each 1 cycle after acceptance; in_ready stays 1.
- Backpressure: out_ready=0, send 0xA1,0xA2 -> in_ready=0 after the second acceptance, stall_cnt counts 1,2,3...; release out_ready -> 0xA1 then 0xA2 in order, no loss.
- Flush in TWO: entries 0xB1,0xB2 held, assert flush with in_valid=1, in_ir=0xB3 -> next cycle out_valid=0, out_ir=NOP, 0xB3 never emitted, stall_cnt unchanged.
- SKID=0: out_ready=0 with one entry held -> in_ready=0 in the same cycle; raise out_ready -> in_ready=1 combinationally and simultaneous in/out keeps occupancy ONE.
- Saturation (CNT_W=4): hold out_valid=1 with out_ready=0 for 20 cycles -> stall_cnt reaches 15 and stays 15.
